// File: rtl/mem_pkg.sv
// Shared definitions for the memory port responder: access-size encodings,
// default storage base address, FSM state type and burst-length decode.
package mem_pkg;

    localparam logic [1:0] AS_1W  = 2'b00;
    localparam logic [1:0] AS_4W  = 2'b01;
    localparam logic [1:0] AS_8W  = 2'b10;
    localparam logic [1:0] AS_16W = 2'b11;

    localparam logic [31:0] MEM_BASE_ADDR = 32'h8002_0000;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    function automatic logic [4:0] burst_len(input logic [1:0] size);
        logic [4:0] len;
        case (size)
            AS_1W:   len = 5'd1;
            AS_4W:   len = 5'd4;
            AS_8W:   len = 5'd8;
            AS_16W:  len = 5'd16;
            default: len = 5'd1;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous word RAM with write enable and a registered read port.
// Contents are never reset; the read register only updates on a read strobe.
module mem_array #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic                  clock,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [IDX_W-1:0]      index,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH_WORDS];
    logic [DATA_WIDTH-1:0] rd_data_r;

    // Storage write and registered read of the addressed word
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_r[index] <= wr_data;
        end
        if (rd_en) begin
            rd_data_r <= mem_r[index];
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/mem_burst_responder.sv
// Responder side of the processor memory port: accepts single/burst requests,
// walks the burst one word per edge and streams read data with one cycle latency.
module mem_burst_responder
    import mem_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DEPTH_WORDS = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = ADDR_WIDTH'(MEM_BASE_ADDR)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  rw,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [1:0]            access_size,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  addr_err
);

    localparam int                    IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [ADDR_WIDTH-1:0] SPAN  = ADDR_WIDTH'(DEPTH_WORDS) << 2;

    state_e                state_r;
    logic [4:0]            len_r;
    logic [4:0]            beat_r;
    logic [IDX_W-1:0]      idx_r;
    logic                  rw_r;
    logic                  ok_r;
    logic                  busy_r;
    logic                  valid_r;
    logic                  err_r;
    logic                  zero_r;

    logic [ADDR_WIDTH-1:0] offset_s;
    logic                  in_range_s;
    logic [IDX_W-1:0]      req_idx_s;
    logic [4:0]            req_len_s;
    logic                  start_s;
    logic                  active_s;
    logic [IDX_W-1:0]      cur_idx_s;
    logic                  cur_rw_s;
    logic                  cur_ok_s;
    logic                  wr_en_s;
    logic                  rd_en_s;
    logic [DATA_WIDTH-1:0] ram_q_s;

    // Request decode and selection of the beat performed at the coming edge
    always_comb begin
        offset_s   = address - BASE_ADDR;
        in_range_s = (address >= BASE_ADDR) && (offset_s < SPAN);
        req_idx_s  = offset_s[IDX_W+1:2];
        req_len_s  = burst_len(access_size);
        start_s    = (state_r == IDLE) && enable;
        active_s   = start_s || (state_r == BURST);
        if (start_s) begin
            cur_idx_s = req_idx_s;
            cur_rw_s  = rw;
            cur_ok_s  = in_range_s;
        end else begin
            // index arithmetic wraps naturally at the storage size
            cur_idx_s = idx_r + IDX_W'(beat_r);
            cur_rw_s  = rw_r;
            cur_ok_s  = ok_r;
        end
        wr_en_s = active_s && !cur_rw_s && cur_ok_s;
        rd_en_s = active_s && cur_rw_s && cur_ok_s;
    end

    // Burst sequencer with registered status outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
            len_r   <= 5'd0;
            beat_r  <= 5'd0;
            idx_r   <= {IDX_W{1'b0}};
            rw_r    <= 1'b0;
            ok_r    <= 1'b0;
            busy_r  <= 1'b0;
            valid_r <= 1'b0;
            err_r   <= 1'b0;
            zero_r  <= 1'b1;
        end else begin
            valid_r <= active_s && cur_rw_s;
            err_r   <= start_s && !in_range_s;
            // out-of-range read beats present zero instead of the RAM register
            if (active_s && cur_rw_s) begin
                zero_r <= !cur_ok_s;
            end else begin
                zero_r <= zero_r;
            end
            case (state_r)
                IDLE: begin
                    if (enable) begin
                        len_r   <= req_len_s;
                        idx_r   <= req_idx_s;
                        rw_r    <= rw;
                        ok_r    <= in_range_s;
                        beat_r  <= 5'd1;
                        busy_r  <= (req_len_s > 5'd1);
                        state_r <= (req_len_s > 5'd1) ? BURST : IDLE;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                BURST: begin
                    beat_r <= beat_r + 5'd1;
                    // busy drops one cycle ahead of the final beat
                    busy_r <= (({1'b0, beat_r} + 6'd2) < {1'b0, len_r});
                    if (beat_r == (len_r - 5'd1)) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= BURST;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign busy       = busy_r;
    assign data_valid = valid_r;
    assign addr_err   = err_r;
    assign data_out   = zero_r ? {DATA_WIDTH{1'b0}} : ram_q_s;

    mem_array #(
        .DATA_WIDTH  (DATA_WIDTH),
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_ram (
        .clock   (clock),
        .wr_en   (wr_en_s),
        .rd_en   (rd_en_s),
        .index   (cur_idx_s),
        .wr_data (data_in),
        .rd_data (ram_q_s)
    );

endmodule

// File: tb/tb_mem_burst_responder.sv
// Self-checking bench for mem_burst_responder: table vectors, directed corner
// sequences and random requests checked against a word-array reference model.
module tb_mem_burst_responder;

    localparam int          D    = 1024;
    localparam logic [31:0] BASE = 32'h8002_0000;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        rw;
    logic [31:0] address;
    logic [1:0]  access_size;
    logic [31:0] data_in;
    logic        busy;
    logic [31:0] data_out;
    logic        data_valid;
    logic        addr_err;

    always #5 clock = ~clock;

    mem_burst_responder dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .enable      (enable),
        .rw          (rw),
        .address     (address),
        .access_size (access_size),
        .data_in     (data_in),
        .busy        (busy),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .addr_err    (addr_err)
    );

    logic [31:0] model [D];
    logic [31:0] wd [16];
    logic [31:0] rd [16];
    logic [31:0] exp_dout;
    int          n_pass  = 0;
    int          n_total = 0;

    typedef struct {
        logic        r;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp_dout;
        logic        exp_err;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    // Issue one request starting at the current negedge; check every beat.
    task automatic do_req(input logic r, input logic [31:0] a, input logic [1:0] sz,
                          output logic [31:0] last_d, output int busy_cnt, output logic err_seen);
        int     len;
        longint off;
        bit     ok;
        int     idx;
        case (sz)
            2'b00:   len = 1;
            2'b01:   len = 4;
            2'b10:   len = 8;
            default: len = 16;
        endcase
        off = longint'(a) - longint'(BASE);
        ok  = (off >= 0) && (off < 4 * D);
        idx = ok ? int'(off >>> 2) : 0;
        enable = 1'b1; rw = r; address = a; access_size = sz; data_in = wd[0];
        busy_cnt = 0; err_seen = 1'b0;
        for (int k = 0; k < len; k++) begin
            @(posedge clock);
            @(negedge clock);
            if (!r && ok) model[(idx + k) % D] = wd[k];
            if (r) exp_dout = ok ? model[(idx + k) % D] : 32'h0;
            chk("busy",  {31'b0, busy},       {31'b0, (len > 1) && (k < len - 2)});
            chk("valid", {31'b0, data_valid}, {31'b0, r});
            chk("dout",  data_out, exp_dout);
            chk("err",   {31'b0, addr_err},   {31'b0, (k == 0) && !ok});
            rd[k]    = data_out;
            busy_cnt += int'(busy);
            err_seen |= addr_err;
            if ((len > 1) && (k < len - 2)) begin
                enable = 1'($urandom); rw = 1'($urandom);
                address = $urandom; access_size = 2'($urandom);
            end else begin
                enable = 1'b0;
            end
            if (k + 1 < len) data_in = wd[k + 1];
        end
        last_d = data_out;
    endtask

    initial begin
        vec_t        tbl [8];
        logic [31:0] exp4 [4];
        logic [31:0] ld;
        int          bc;
        logic        es;
        logic [31:0] ra;

        reset_n = 1'b0; enable = 1'b0; rw = 1'b0; address = 32'h0;
        access_size = 2'b00; data_in = 32'h0; exp_dout = 32'h0;
        #12;
        chk("rst_busy",  {31'b0, busy},       32'd0);
        chk("rst_valid", {31'b0, data_valid}, 32'd0);
        chk("rst_dout",  data_out,            32'd0);
        chk("rst_err",   {31'b0, addr_err},   32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        // fill all storage with back-to-back 16-word bursts
        for (int i = 0; i < 64; i++) begin
            for (int j = 0; j < 16; j++) wd[j] = $urandom;
            do_req(1'b0, BASE + 32'(i * 64), 2'b11, ld, bc, es);
        end

        tbl[0] = '{1'b0, 32'h8002_0000, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
        tbl[1] = '{1'b1, 32'h8002_0000, 32'h0,         32'hDEAD_BEEF, 1'b0};
        tbl[2] = '{1'b0, 32'h8002_0FFC, 32'h1234_5678, 32'hDEAD_BEEF, 1'b0};
        tbl[3] = '{1'b1, 32'h8002_0FFF, 32'h0,         32'h1234_5678, 1'b0};
        tbl[4] = '{1'b0, 32'h8002_1000, 32'h0000_AAAA, 32'h1234_5678, 1'b1};
        tbl[5] = '{1'b1, 32'h8002_1000, 32'h0,         32'h0000_0000, 1'b1};
        tbl[6] = '{1'b1, 32'h8001_FFFC, 32'h0,         32'h0000_0000, 1'b1};
        tbl[7] = '{1'b1, 32'h8002_0002, 32'h0,         32'hDEAD_BEEF, 1'b0};
        for (int i = 0; i < 8; i++) begin
            wd[0] = tbl[i].d;
            do_req(tbl[i].r, tbl[i].a, 2'b00, ld, bc, es);
            chk("tbl_dout", ld, tbl[i].exp_dout);
            chk("tbl_err",  {31'b0, es}, {31'b0, tbl[i].exp_err});
            chk("tbl_busy", 32'(bc), 32'd0);
        end

        // 16-word write wrapping past the top of storage
        for (int k = 0; k < 16; k++) wd[k] = 32'h1000 + 32'(k);
        do_req(1'b0, BASE + 32'(4 * (D - 2)), 2'b11, ld, bc, es);
        chk("wrap_err", {31'b0, es}, 32'd0);
        for (int k = 0; k < 16; k++) begin
            do_req(1'b1, BASE + 32'(4 * ((D - 2 + k) % D)), 2'b00, ld, bc, es);
            chk("wrap_rd", ld, 32'h1000 + 32'(k));
        end

        // burst-4 write then read
        wd[0] = 32'h11; wd[1] = 32'h22; wd[2] = 32'h33; wd[3] = 32'h44;
        exp4[0] = 32'h11; exp4[1] = 32'h22; exp4[2] = 32'h33; exp4[3] = 32'h44;
        do_req(1'b0, 32'h8002_0010, 2'b01, ld, bc, es);
        chk("b4_busy_cycles", 32'(bc), 32'd2);
        do_req(1'b1, 32'h8002_0010, 2'b01, ld, bc, es);
        for (int k = 0; k < 4; k++) chk("b4_rd", rd[k], exp4[k]);

        // out-of-range write is dropped, out-of-range read returns zeros
        for (int k = 0; k < 4; k++) wd[k] = 32'hBAD0_0000 + 32'(k);
        do_req(1'b0, 32'h9000_0000, 2'b01, ld, bc, es);
        chk("oor_wr_err", {31'b0, es}, 32'd1);
        do_req(1'b1, 32'h8000_0000, 2'b01, ld, bc, es);
        chk("oor_rd_err", {31'b0, es}, 32'd1);
        for (int k = 0; k < 4; k++) chk("oor_rd", rd[k], 32'h0);
        do_req(1'b1, 32'h8002_0010, 2'b00, ld, bc, es);
        chk("oor_keep", ld, 32'h11);

        // 8-word read with junk requests while busy, then immediate follow-up
        do_req(1'b1, BASE + 32'(4 * 100), 2'b10, ld, bc, es);
        do_req(1'b1, BASE + 32'(4 * 5), 2'b00, ld, bc, es);
        chk("after_busy_rd", ld, 32'h22);

        // reset during beat 2 of a 4-word write
        wd[0] = 32'h55; do_req(1'b0, BASE + 32'(4 * 202), 2'b00, ld, bc, es);
        wd[0] = 32'h66; do_req(1'b0, BASE + 32'(4 * 203), 2'b00, ld, bc, es);
        do_req(1'b1, 32'h8002_0010, 2'b00, ld, bc, es);
        enable = 1'b1; rw = 1'b0; address = BASE + 32'(4 * 200);
        access_size = 2'b01; data_in = 32'hA0;
        @(posedge clock); @(negedge clock);
        enable = 1'b0; data_in = 32'hA1;
        @(posedge clock); #2;
        chk("rst_mid_busy_pre", {31'b0, busy}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("rst_mid_busy",  {31'b0, busy},       32'd0);
        chk("rst_mid_valid", {31'b0, data_valid}, 32'd0);
        chk("rst_mid_dout",  data_out,            32'd0);
        model[200] = 32'hA0; model[201] = 32'hA1; exp_dout = 32'h0;
        @(negedge clock); data_in = 32'hA2;
        @(negedge clock); data_in = 32'hA3;
        @(negedge clock); reset_n = 1'b1;
        do_req(1'b1, BASE + 32'(4 * 200), 2'b00, ld, bc, es); chk("rst_w0", ld, 32'hA0);
        do_req(1'b1, BASE + 32'(4 * 201), 2'b00, ld, bc, es); chk("rst_w1", ld, 32'hA1);
        do_req(1'b1, BASE + 32'(4 * 202), 2'b00, ld, bc, es); chk("rst_w2", ld, 32'h55);
        do_req(1'b1, BASE + 32'(4 * 203), 2'b00, ld, bc, es); chk("rst_w3", ld, 32'h66);

        // random traffic against the model
        for (int i = 0; i < 60; i++) begin
            for (int j = 0; j < 16; j++) wd[j] = $urandom;
            if ($urandom_range(7) == 0) ra = $urandom;
            else ra = BASE + ($urandom % 32'(4 * D));
            do_req(1'($urandom), ra, 2'($urandom), ld, bc, es);
        end

        enable = 1'b0;
        repeat (3) @(negedge clock);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
